// File: rtl/decoder_controller.sv
// decoder_controller
// Sequencing FSM for the matrix decoder. Walks the inverse round steps
// (inv AddRC, inv Revalute, inv Permute, inv Rotate, inv ColParity) for
// rounds ROUNDS-1 down to 0. Exactly one step enable is raised at a time,
// and the FSM waits for that step's done before moving on.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               decode request, honoured only in Idle
//   done1..done5        per-step completion (AddRC..ColParity)
//   wr_en               one-cycle load of the input matrix
//   inv_*_en            step enables, Moore-decoded from the state
//   round_idx           current round, counts down, feeds the RC ROM
//   busy                high in every state except Idle
//   done                one-cycle pulse when the decoded matrix is valid
module decoder_controller #(
    parameter int ROUNDS = 24,
    parameter int RW     = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          done1,
    input  logic          done2,
    input  logic          done3,
    input  logic          done4,
    input  logic          done5,
    output logic          wr_en,
    output logic          inv_addRC_en,
    output logic          inv_revalute_en,
    output logic          inv_permute_en,
    output logic          inv_rotate_en,
    output logic          inv_colParity_en,
    output logic [RW-1:0] round_idx,
    output logic          busy,
    output logic          done
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD,
        S_ADDRC,
        S_REVAL,
        S_PERM,
        S_ROT,
        S_COLP,
        S_RDEC,
        S_FIN
    } state_t;

    localparam logic [RW-1:0] LAST_ROUND = RW'(ROUNDS - 1);

    state_t ps, ns;

    // State register and round down-counter. The counter only moves in
    // RoundDec, so it is stable across all five steps of a round, and it
    // saturates at 0 (the last RoundDec exits to Finish instead).
    always_ff @(posedge clk) begin
        if (rst) begin
            ps        <= S_IDLE;
            round_idx <= LAST_ROUND;
        end else begin
            ps <= ns;
            case (ps)
                S_IDLE, S_FIN: round_idx <= LAST_ROUND;
                S_RDEC: begin
                    if (round_idx != '0)
                        round_idx <= round_idx - 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Next state and Moore outputs. Each doneN is only looked at in the
    // state that owns it, so stray completions elsewhere have no effect.
    always_comb begin
        ns               = ps;
        wr_en            = 1'b0;
        inv_addRC_en     = 1'b0;
        inv_revalute_en  = 1'b0;
        inv_permute_en   = 1'b0;
        inv_rotate_en    = 1'b0;
        inv_colParity_en = 1'b0;
        done             = 1'b0;
        busy             = (ps != S_IDLE);
        case (ps)
            S_IDLE: if (start) ns = S_LOAD;
            S_LOAD: begin
                wr_en = 1'b1;
                ns    = S_ADDRC;
            end
            S_ADDRC: begin
                inv_addRC_en = 1'b1;
                if (done1) ns = S_REVAL;
            end
            S_REVAL: begin
                inv_revalute_en = 1'b1;
                if (done2) ns = S_PERM;
            end
            S_PERM: begin
                inv_permute_en = 1'b1;
                if (done3) ns = S_ROT;
            end
            S_ROT: begin
                inv_rotate_en = 1'b1;
                if (done4) ns = S_COLP;
            end
            S_COLP: begin
                inv_colParity_en = 1'b1;
                if (done5) ns = S_RDEC;
            end
            S_RDEC: ns = (round_idx == '0) ? S_FIN : S_ADDRC;
            S_FIN: begin
                done = 1'b1;
                ns   = S_IDLE;
            end
            default: ns = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_decoder_controller.sv
// Bench for decoder_controller. A schedule model tracks the position in the
// linear decode sequence (Load, 6 slots per round, Finish) and derives the
// expected outputs arithmetically; every cycle is compared. Directed tests
// add literal expectations on cycle numbers taken from the timing rules.
module tb_decoder_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [4:0] dn;
    logic       start2;
    logic       d_hi;

    logic       wr_en, e1, e2, e3, e4, e5, busy, done;
    logic [4:0] round_idx;
    logic       b_wr_en, b_e1, b_e2, b_e3, b_e4, b_e5, b_busy, b_done;
    logic [1:0] b_round_idx;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int pos_a  = -1;
    int pos_b  = -1;
    bit chk_on = 1'b0;

    logic [7:0] a_log [0:4095];
    int         ra_log[0:4095];
    logic [7:0] b_log [0:4095];
    int         rb_log[0:4095];
    int n_wr = 0, n_done = 0, perm_cur = 0, perm_max = 0;

    always #5 clk = ~clk;

    decoder_controller #(.ROUNDS(24), .RW(5)) u_dut (
        .clk(clk), .rst(rst), .start(start),
        .done1(dn[0]), .done2(dn[1]), .done3(dn[2]), .done4(dn[3]), .done5(dn[4]),
        .wr_en(wr_en), .inv_addRC_en(e1), .inv_revalute_en(e2),
        .inv_permute_en(e3), .inv_rotate_en(e4), .inv_colParity_en(e5),
        .round_idx(round_idx), .busy(busy), .done(done)
    );

    decoder_controller #(.ROUNDS(2), .RW(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2),
        .done1(d_hi), .done2(d_hi), .done3(d_hi), .done4(d_hi), .done5(d_hi),
        .wr_en(b_wr_en), .inv_addRC_en(b_e1), .inv_revalute_en(b_e2),
        .inv_permute_en(b_e3), .inv_rotate_en(b_e4), .inv_colParity_en(b_e5),
        .round_idx(b_round_idx), .busy(b_busy), .done(b_done)
    );

    wire [7:0] a_ctrl = {wr_en, e1, e2, e3, e4, e5, busy, done};
    wire [7:0] b_ctrl = {b_wr_en, b_e1, b_e2, b_e3, b_e4, b_e5, b_busy, b_done};

    // Position p: -1 idle, 0 load, 1..6R round slots (slot 5 of each round
    // is the decrement), 6R+1 finish.
    function automatic int nxt(int p, logic s, logic [4:0] d, int r);
        int k;
        if (p < 0) return s ? 0 : -1;
        if (p == 0) return 1;
        if (p <= 6 * r) begin
            k = (p - 1) % 6;
            if (k == 5) return p + 1;
            return d[k] ? p + 1 : p;
        end
        return -1;
    endfunction

    function automatic logic [7:0] exp_ctrl(int p, int r);
        logic [7:0] v;
        int k;
        v = '0;
        if (p < 0) return v;
        v[1] = 1'b1;
        if (p == 0) v[7] = 1'b1;
        else if (p <= 6 * r) begin
            k = (p - 1) % 6;
            if (k < 5) v[6-k] = 1'b1;
        end else v[0] = 1'b1;
        return v;
    endfunction

    function automatic int exp_ridx(int p, int r);
        if (p <= 0) return r - 1;
        if (p <= 6 * r) return r - 1 - (p - 1) / 6;
        return 0;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            pos_a = -1;
            pos_b = -1;
        end else begin
            pos_a = nxt(pos_a, start, dn, 24);
            pos_b = nxt(pos_b, start2, {5{d_hi}}, 2);
        end
    end

    // Compare and log, once per cycle away from the active edge.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("ctrl_a", int'(a_ctrl), int'(exp_ctrl(pos_a, 24)));
            chk("ridx_a", int'(round_idx), exp_ridx(pos_a, 24));
            chk("ctrl_b", int'(b_ctrl), int'(exp_ctrl(pos_b, 2)));
            chk("ridx_b", int'(b_round_idx), exp_ridx(pos_b, 2));
        end
        if (cyc < 4096) begin
            a_log[cyc]  = a_ctrl;
            ra_log[cyc] = int'(round_idx);
            b_log[cyc]  = b_ctrl;
            rb_log[cyc] = int'(b_round_idx);
        end
        if (wr_en) n_wr++;
        if (done) n_done++;
        if (e3) perm_cur++; else perm_cur = 0;
        if (perm_cur > perm_max) perm_max = perm_cur;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic to_cycle(input int c);
        while (cyc < c) tick();
    endtask

    task automatic pulse_start(output int t0);
        t0    = cyc;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int which, input int t0, output int rel);
        rel = -1;
        while (cyc - t0 <= 400) begin
            if (which == 0 ? a_log[cyc][0] : b_log[cyc][0]) begin
                rel = cyc - t0;
                return;
            end
            tick();
        end
        errors++;
        $display("FAIL wait_done timeout: got no done, expected one within 400 cycles");
    endtask

    task automatic clear_counts();
        n_wr = 0; n_done = 0; perm_max = 0;
    endtask

    initial begin
        int t0, rel;
        // Reset with random inputs on both reset cycles
        rst = 1'b1; start = 1'($urandom); dn = 5'($urandom); start2 = 1'b0; d_hi = 1'b1;
        @(posedge clk);
        tick();
        chk_on = 1'b1;
        start = 1'($urandom); dn = 5'($urandom);
        @(posedge clk);
        tick();
        chk("reset_ctrl", int'(a_ctrl), 0);
        chk("reset_ridx", int'(round_idx), 23);
        rst = 1'b0; start = 1'b0; dn = '0;

        // Spurious dones in Idle
        clear_counts();
        for (int i = 0; i < 5; i++) begin
            dn = 5'(1 << i);
            tick();
        end
        dn = '0;
        tick();
        chk("idle_no_load", n_wr, 0);
        chk("idle_busy", int'(busy), 0);
        chk("idle_ridx", int'(round_idx), 23);

        // Full run, dones high, stray start at cycle 50
        dn = 5'h1f;
        clear_counts();
        pulse_start(t0);
        to_cycle(t0 + 50);
        start = 1'b1; tick(); start = 1'b0;
        wait_done(0, t0, rel);
        chk("full_done_cycle", rel, 146);
        to_cycle(t0 + 148);
        chk("full_wr_c1", int'(a_log[t0+1]), 8'h82);
        chk("full_addrc_c2", int'(a_log[t0+2]), 8'h42);
        chk("full_ridx_c2", ra_log[t0+2], 23);
        chk("full_ridx_c139", ra_log[t0+139], 1);
        chk("full_ridx_c140", ra_log[t0+140], 0);
        chk("full_ridx_c145", ra_log[t0+145], 0);
        chk("full_busy_c147", int'(a_log[t0+147][1]), 0);
        chk("full_one_load", n_wr, 1);
        chk("full_one_done", n_done, 1);

        // Stall inverse Permute in round 23 by four cycles
        clear_counts();
        pulse_start(t0);
        to_cycle(t0 + 4);
        dn[2] = 1'b0;
        to_cycle(t0 + 8);
        dn[2] = 1'b1;
        wait_done(0, t0, rel);
        chk("stall_done_cycle", rel, 150);
        chk("stall_perm_run", perm_max, 5);
        chk("stall_perm_c8", int'(a_log[t0+8]), 8'h12);
        chk("stall_rot_c9", int'(a_log[t0+9]), 8'h0a);
        to_cycle(t0 + 152);

        // done5 during a held InvAddRC must not advance it
        dn = '0;
        pulse_start(t0);
        to_cycle(t0 + 2);
        dn[4] = 1'b1;
        tick();
        dn[4] = 1'b0;
        tick();
        chk("spur_d5_addrc", int'(a_log[t0+4]), 8'h42);
        dn = 5'h1f;
        wait_done(0, t0, rel);
        chk("spur_done_cycle", rel, 148);
        to_cycle(t0 + 150);

        // Mid-run reset at round 10, InvRotate
        pulse_start(t0);
        while (!(e4 && round_idx == 5'd10) && cyc - t0 < 400) tick();
        chk("mid_reached", int'(e4 && round_idx == 5'd10), 1);
        rst = 1'b1;
        tick();
        chk("mid_ctrl", int'(a_ctrl), 0);
        chk("mid_ridx", int'(round_idx), 23);
        rst = 1'b0;
        tick();
        pulse_start(t0);
        wait_done(0, t0, rel);
        chk("mid_rerun_done", rel, 146);
        to_cycle(t0 + 148);

        // ROUNDS=2 instance, back-to-back starts
        t0 = cyc;
        start2 = 1'b1; tick(); start2 = 1'b0;
        wait_done(1, t0, rel);
        chk("r2_done_cycle", rel, 14);
        to_cycle(t0 + 15);
        start2 = 1'b1; tick(); start2 = 1'b0;
        to_cycle(t0 + 16);
        wait_done(1, t0, rel);
        chk("r2_second_done", rel, 29);
        chk("r2_ridx_c2", rb_log[t0+2], 1);
        chk("r2_ridx_c8", rb_log[t0+8], 0);
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
